// File: rtl/led_pattern_if.sv
// led_pattern_if: control inputs and LED/pulse outputs of the LED pattern engine
interface led_pattern_if #(parameter int N_LED = 10);
  logic [2:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic             step;
  logic [N_LED-1:0] led_pin;
  logic             tick;
  logic             wrap;
  modport master (output mode, speed, pause, step, input led_pin, tick, wrap);
  modport slave  (input mode, speed, pause, step, output led_pin, tick, wrap);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled multi-mode LED pattern engine with pause/single-step
module led_pattern_gen #(
  parameter int N_LED    = 10,
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         nrst,
  led_pattern_if.slave bus
);
  localparam logic [2:0] M_ROTL   = 3'd0;
  localparam logic [2:0] M_ROTR   = 3'd1;
  localparam logic [2:0] M_BOUNCE = 3'd2;
  localparam logic [2:0] M_COUNT  = 3'd3;
  localparam logic [2:0] M_FILL   = 3'd4;
  localparam logic [2:0] M_BLINK  = 3'd5;
  localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);
  localparam logic [N_LED-1:0] ONE = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] TOP = {1'b1, {(N_LED-1){1'b0}}};
  logic [CNT_W-1:0] cnt, shr, limit;
  logic [N_LED-1:0] pat, nxt, start;
  logic [2:0]       mode_q;
  logic             dir, dir_n, adv, hit, chg, w, tick_q, wrap_q;
  assign bus.led_pin = pat;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  // dir=1 means moving down (towards bit 0); flips at the ends without dwelling
  always_comb begin
    shr   = DIV >> bus.speed;
    limit = shr == '0 ? '0 : shr - CNT_W'(1);
    hit   = cnt >= limit;
    chg   = bus.mode != mode_q;
    adv   = bus.pause ? bus.step : hit;
    start = bus.mode == M_ROTR ? TOP :
            (bus.mode == M_ROTL || bus.mode == M_BOUNCE) ? ONE :
            bus.mode[2:1] == 2'b11 ? pat : '0;
    dir_n = dir;
    nxt   = pat;
    w     = 1'b0;
    case (mode_q)
      M_ROTL:   begin nxt = {pat[N_LED-2:0], pat[N_LED-1]}; w = nxt == ONE; end
      M_ROTR:   begin nxt = {pat[0], pat[N_LED-1:1]}; w = nxt == TOP; end
      M_BOUNCE: begin
        dir_n = dir ? !pat[0] : pat[N_LED-1];
        nxt   = dir_n ? pat >> 1 : pat << 1;
        w     = nxt == ONE;
      end
      M_COUNT:  begin nxt = pat + ONE; w = nxt == '0; end
      M_FILL:   begin nxt = &pat ? '0 : {pat[N_LED-2:0], 1'b1}; w = &pat; end
      M_BLINK:  begin nxt = ~pat; w = &pat; end
      default:  ;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      pat    <= ONE;
      dir    <= 1'b0;
      mode_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (chg) begin
      mode_q <= bus.mode;
      cnt    <= '0;
      dir    <= 1'b0;
      pat    <= start;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= bus.pause ? cnt : hit ? '0 : cnt + CNT_W'(1);
      tick_q <= adv;
      wrap_q <= adv & w;
      if (adv) begin
        pat <= nxt;
        dir <= dir_n;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench; u0 (TICK_DIV=16) exercises all modes, u1 (TICK_DIV=4, speed 3) the clamped limit
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  led_pattern_if #(.N_LED(4)) b0();
  led_pattern_if #(.N_LED(4)) b1();
  led_pattern_gen #(.N_LED(4), .TICK_DIV(16), .CNT_W(8)) u0 (.clk(clk), .nrst(nrst), .bus(b0.slave));
  led_pattern_gen #(.N_LED(4), .TICK_DIV(4),  .CNT_W(4)) u1 (.clk(clk), .nrst(nrst), .bus(b1.slave));
  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];
  logic [3:0]  m_pat, m1;
  logic        m_dir;
  logic [2:0]  m_mode;
  int          m_cnt;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_pat = 4'd1; m_dir = 1'b0; m_mode = 3'd0; m_cnt = 0; m1 = 4'd1;
  endtask
  // reference model for one clock edge; u1 advances on every edge
  task automatic model();
    int lim;
    logic adv, t, w;
    logic [3:0] n;
    lim = 16 >> b0.speed;
    if (lim > 0) lim--;
    t = 1'b0; w = 1'b0; n = m_pat;
    if (b0.mode != m_mode) begin
      m_mode = b0.mode; m_cnt = 0; m_dir = 1'b0;
      if (m_mode == 3'd0 || m_mode == 3'd2) m_pat = 4'd1;
      else if (m_mode == 3'd1) m_pat = 4'd8;
      else if (m_mode < 3'd6) m_pat = 4'd0;
    end else begin
      adv = b0.pause ? b0.step : (m_cnt >= lim);
      if (!b0.pause) m_cnt = (m_cnt >= lim) ? 0 : m_cnt + 1;
      if (adv) begin
        case (m_mode)
          3'd0: begin n = (m_pat << 1) | (m_pat >> 3); w = n == 4'd1; end
          3'd1: begin n = (m_pat >> 1) | (m_pat << 3); w = n == 4'd8; end
          3'd2: begin
            if (!m_dir && m_pat == 4'd8) m_dir = 1'b1;
            else if (m_dir && m_pat == 4'd1) m_dir = 1'b0;
            n = m_dir ? m_pat >> 1 : m_pat << 1;
            w = n == 4'd1;
          end
          3'd3: begin n = m_pat + 4'd1; w = n == 4'd0; end
          3'd4: begin n = (m_pat == 4'hF) ? 4'd0 : ((m_pat << 1) | 4'd1); w = n == 4'd0; end
          3'd5: begin n = ~m_pat; w = n == 4'd0; end
          default: n = m_pat;
        endcase
        m_pat = n;
        t = 1'b1;
      end
    end
    m1 = (m1 << 1) | (m1 >> 3);
    sb.push_back({m_pat, t, w, m1, 1'b1, m1 == 4'd1});
  endtask
  task automatic cyc(int n, string tag);
    repeat (n) begin
      model();
      @(posedge clk);
      @(negedge clk);
      chk(tag, {b0.led_pin, b0.tick, b0.wrap, b1.led_pin, b1.tick, b1.wrap}, sb.pop_front());
    end
  endtask
  initial begin
    b0.mode = 3'd0; b0.speed = 2'd2; b0.pause = 1'b0; b0.step = 1'b0;
    b1.mode = 3'd0; b1.speed = 2'd3; b1.pause = 1'b0; b1.step = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", b0.led_pin, 4'b0001);
    chk("rst_tick", b0.tick, 1'b0);
    chk("rst_wrap", b0.wrap, 1'b0);
    chk("rst_led1", b1.led_pin, 4'b0001);
    model_reset();
    nrst = 1'b1;
    cyc(3, "rotl_hold");
    chk("rotl_first", b0.led_pin, 4'b0001);
    cyc(1, "rotl_adv");
    chk("rotl_step", b0.led_pin, 4'b0010);
    cyc(16, "rotl");
    b0.mode = 3'd2;
    cyc(30, "bounce");
    b0.mode = 3'd3;
    cyc(70, "count");
    b0.mode = 3'd4;
    cyc(1, "fill_load");
    chk("fill_zero", b0.led_pin, 4'b0000);
    cyc(24, "fill");
    b0.mode = 3'd0;
    cyc(2, "rotl2");
    b0.pause = 1'b1;
    cyc(20, "pause");
    repeat (3) begin
      b0.step = 1'b1;
      cyc(1, "step");
      chk("step_tick", b0.tick, 1'b1);
      b0.step = 1'b0;
      cyc(2, "step_gap");
    end
    b0.pause = 1'b0;
    b0.step = 1'b1;
    cyc(1, "step_run");
    b0.step = 1'b0;
    cyc(8, "run");
    b0.mode = 3'd1; b0.speed = 2'd0;
    cyc(13, "slow");
    b0.speed = 2'd2;
    cyc(1, "spd");
    chk("spd_tick", b0.tick, 1'b1);
    cyc(12, "spd4");
    b0.speed = 2'd3;
    cyc(6, "spd3");
    b0.mode = 3'd6;
    cyc(6, "hold");
    b0.speed = 2'd2; b0.mode = 3'd5;
    cyc(6, "blink");
    chk("blink_on", b0.led_pin, 4'hF);
    #2 nrst = 1'b0;
    #1 chk("arst_led", b0.led_pin, 4'b0001);
    chk("arst_tick", b0.tick, 1'b0);
    model_reset();
    sb.delete();
    #1 nrst = 1'b1;
    cyc(1, "reload");
    chk("reload_led", b0.led_pin, 4'b0000);
    chk("reload_tick", b0.tick, 1'b0);
    cyc(10, "blink2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
